// File: rtl/mem_access_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : mem_access_arbiter_if
//  Purpose  : Bundles the fetch requester, MEM-stage requester and byte-RAM
//             signals of mem_access_arbiter. The slave modport is the arbiter
//             view; the master modport is the requester/RAM side.
//  Revision : 1.0  initial release
// ============================================================================
interface mem_access_arbiter_if #(
    parameter int ADDR_W = 32
);
    // MEM-stage requester
    logic              d_req;
    logic              d_we;
    logic [1:0]        d_load_mode;
    logic [ADDR_W-1:0] d_addr;
    logic [31:0]       d_wdata;
    logic [31:0]       d_rdata;
    logic              d_ack;
    logic              d_err;
    // instruction-fetch requester
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic [31:0]       i_rdata;
    logic              i_ack;
    // byte-wide synchronous-read RAM
    logic              m_en;
    logic              m_we;
    logic [ADDR_W-1:0] m_addr;
    logic [7:0]        m_wdata;
    logic [7:0]        m_rdata;
    // status
    logic              busy;

    modport slave (
        input  d_req, d_we, d_load_mode, d_addr, d_wdata,
        output d_rdata, d_ack, d_err,
        input  i_req, i_addr,
        output i_rdata, i_ack,
        output m_en, m_we, m_addr, m_wdata,
        input  m_rdata,
        output busy
    );

    modport master (
        output d_req, d_we, d_load_mode, d_addr, d_wdata,
        input  d_rdata, d_ack, d_err,
        output i_req, i_addr,
        input  i_rdata, i_ack,
        input  m_en, m_we, m_addr, m_wdata,
        output m_rdata,
        input  busy
    );
endinterface
`default_nettype wire

// File: rtl/mem_access_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_access_arbiter
//  Purpose  : Shares one byte-wide synchronous-read RAM between instruction
//             fetch (i_*) and the MEM stage (d_*). Each access is serialised
//             into big-endian byte beats; loads are assembled as word, signed
//             half or unsigned half. One ack pulse per completed access.
//  Options  : ALIGN_CHECK_EN - when defined, misaligned accesses are rejected
//             with no RAM beats (d_err for the data side, zero i_rdata for
//             fetch).
//  Revision : 1.0  initial release
// ============================================================================
module mem_access_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int ADDR_W       = 32
) (
    input  wire logic            clk,
    input  wire logic            reset,
    mem_access_arbiter_if.slave  bus
);

    localparam int c_starve_w = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [c_starve_w-1:0] c_starve_max = c_starve_w'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_XFER  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_ACK   = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_owner_i;
    logic [ADDR_W-1:0]     r_addr;
    logic [31:0]           r_wdata;
    logic [1:0]            r_mode;
    logic                  r_we;
    logic                  r_err;
    logic [1:0]            r_beat;
    logic [31:0]           r_asm;
    logic [c_starve_w-1:0] r_starve;

    logic                  w_req_any;
    logic                  w_i_win;
    logic                  w_d_illegal;
    logic                  w_d_misalign;
    logic                  w_i_misalign;
    logic                  w_sel_err;
    logic                  w_last_beat;
    logic                  w_xfer;
    logic                  w_ack;
    logic [31:0]           w_result;

    assign w_req_any   = bus.d_req | bus.i_req;
    assign w_d_illegal = !bus.d_we && (bus.d_load_mode == 2'b11);

`ifdef ALIGN_CHECK_EN
    // Writes and word loads need 4-byte alignment, half loads 2-byte.
    assign w_d_misalign = (bus.d_we || bus.d_load_mode == 2'b00) ? (bus.d_addr[1:0] != 2'b00)
                                                                 : bus.d_addr[0];
    assign w_i_misalign = (bus.i_addr[1:0] != 2'b00);
`else
    assign w_d_misalign = 1'b0;
    assign w_i_misalign = 1'b0;
`endif

    // Data side wins unless fetch has waited through STARVE_LIMIT data grants.
    assign w_i_win   = bus.i_req &&
                       (!bus.d_req || ((STARVE_LIMIT != 0) && (r_starve == c_starve_max)));
    assign w_sel_err = w_i_win ? w_i_misalign : (w_d_illegal | w_d_misalign);

    // Writes are latched with mode 00, so only half loads stop after two beats.
    assign w_last_beat = (r_we || r_mode == 2'b00) ? (r_beat == 2'd3) : (r_beat == 2'd1);

    // Next-state logic for the access sequencer.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_req_any) w_state_nxt = w_sel_err ? ST_ACK : ST_XFER;
            ST_XFER:  if (w_last_beat) w_state_nxt = r_we ? ST_ACK : ST_DRAIN;
            ST_DRAIN: w_state_nxt = ST_ACK;
            ST_ACK:   w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Request latch, beat counter, write-byte shifter and load assembly.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_owner_i <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_mode    <= 2'b00;
            r_we      <= 1'b0;
            r_err     <= 1'b0;
            r_beat    <= 2'd0;
            r_asm     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_req_any) begin
                        r_owner_i <= w_i_win;
                        r_addr    <= w_i_win ? bus.i_addr : bus.d_addr;
                        r_wdata   <= w_i_win ? 32'h0 : bus.d_wdata;
                        r_mode    <= (w_i_win || bus.d_we) ? 2'b00 : bus.d_load_mode;
                        r_we      <= !w_i_win && bus.d_we;
                        r_err     <= w_sel_err;
                        r_beat    <= 2'd0;
                        r_asm     <= '0;
                    end
                end
                ST_XFER: begin
                    r_beat <= r_beat + 2'd1;
                    if (r_we) begin
                        r_wdata <= {r_wdata[23:0], 8'h00};
                    end else if (r_beat != 2'd0) begin
                        // RAM returns the previous beat's byte this cycle.
                        r_asm <= {r_asm[23:0], bus.m_rdata};
                    end
                end
                ST_DRAIN: begin
                    r_asm <= {r_asm[23:0], bus.m_rdata};
                end
                default: begin
                end
            endcase
        end
    end

    // Fetch starvation counter: counts data grants while fetch is waiting.
    always_ff @(posedge clk) begin
        if (reset || !bus.i_req) begin
            r_starve <= '0;
        end else if (r_state == ST_IDLE) begin
            if (w_i_win) begin
                r_starve <= '0;
            end else if (bus.d_req && (r_starve != c_starve_max)) begin
                r_starve <= r_starve + 1'b1;
            end
        end
    end

    assign w_xfer = (r_state == ST_XFER);
    assign w_ack  = (r_state == ST_ACK);

    // Assembled bytes sit right-justified; halves are extended per mode.
    assign w_result = (r_mode == 2'b01) ? {{16{r_asm[15]}}, r_asm[15:0]} :
                      (r_mode == 2'b10) ? {16'h0000, r_asm[15:0]} :
                      r_asm;

    assign bus.m_en    = w_xfer;
    assign bus.m_we    = w_xfer && r_we;
    assign bus.m_addr  = w_xfer ? (r_addr + {{(ADDR_W-2){1'b0}}, r_beat}) : '0;
    assign bus.m_wdata = (w_xfer && r_we) ? r_wdata[31:24] : 8'h00;

    assign bus.d_ack   = w_ack && !r_owner_i;
    assign bus.d_err   = w_ack && !r_owner_i && r_err;
    assign bus.d_rdata = (w_ack && !r_owner_i && !r_err) ? w_result : 32'h0;
    assign bus.i_ack   = w_ack && r_owner_i;
    assign bus.i_rdata = (w_ack && r_owner_i && !r_err) ? w_result : 32'h0;
    assign bus.busy    = (r_state != ST_IDLE);

endmodule
`default_nettype wire
